// File: rtl/cache_pkg.sv
// Shared definitions for the cache line data array: default geometry, derived
// field widths, the (set, way, word) -> flat storage address mapping and the
// line-fill FSM state type.
package cache_pkg;

   // Default geometry; modules take these as parameter defaults
   localparam int unsigned DWIDTH_DEF = 32;
   localparam int unsigned SETS_DEF   = 8;
   localparam int unsigned WAYS_DEF   = 2;
   localparam int unsigned WORDS_DEF  = 4;

   // Field widths for the default geometry
   localparam int unsigned SET_W  = $clog2(SETS_DEF);
   localparam int unsigned WAY_W  = $clog2(WAYS_DEF);
   localparam int unsigned OFF_W  = $clog2(WORDS_DEF);
   localparam int unsigned BE_W   = DWIDTH_DEF / 8;
   localparam int unsigned ADDR_W = SET_W + WAY_W + OFF_W;

   // Line-fill engine states
   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

   // Lines of one set are contiguous, words of one line are contiguous
   function automatic int unsigned flat_index(input int unsigned set,
                                              input int unsigned way,
                                              input int unsigned word,
                                              input int unsigned ways,
                                              input int unsigned words);
      return (set * ways + way) * words + word;
   endfunction

endpackage

// File: rtl/cache_line_data_array_if.sv
// CPU access port and refill port of the cache line data array.
// master: tag/controller and memory side; slave: the data array.
interface cache_line_data_array_if import cache_pkg::*; #(
   parameter int unsigned DWIDTH = DWIDTH_DEF,
   parameter int unsigned SETS   = SETS_DEF,
   parameter int unsigned WAYS   = WAYS_DEF,
   parameter int unsigned WORDS  = WORDS_DEF
);
   localparam int unsigned SW = $clog2(SETS);
   localparam int unsigned WW = $clog2(WAYS);
   localparam int unsigned OW = $clog2(WORDS);
   localparam int unsigned BW = DWIDTH / 8;

   // CPU side
   logic              cpu_req;
   logic              cpu_we;
   logic [BW-1:0]     cpu_be;
   logic [SW-1:0]     cpu_set;
   logic [WW-1:0]     cpu_way;
   logic [OW-1:0]     cpu_word;
   logic [DWIDTH-1:0] cpu_wdata;
   logic              cpu_ready;
   logic              rd_valid;
   logic [DWIDTH-1:0] rd_data;
   logic              rd_perr;

   // Refill side
   logic              fill_start;
   logic [SW-1:0]     fill_set;
   logic [WW-1:0]     fill_way;
   logic              fill_valid;
   logic [DWIDTH-1:0] fill_data;
   logic              fill_ready;
   logic              fill_done;
   logic              busy;

   modport master (
      output cpu_req, cpu_we, cpu_be, cpu_set, cpu_way, cpu_word, cpu_wdata,
      input  cpu_ready, rd_valid, rd_data, rd_perr,
      output fill_start, fill_set, fill_way, fill_valid, fill_data,
      input  fill_ready, fill_done, busy
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_be, cpu_set, cpu_way, cpu_word, cpu_wdata,
      output cpu_ready, rd_valid, rd_data, rd_perr,
      input  fill_start, fill_set, fill_way, fill_valid, fill_data,
      output fill_ready, fill_done, busy
   );

endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Line-fill burst engine: latches the target set/way on fill_start, then
// writes one beat per accepted fill_valid into words 0..WORDS-1 in order.
// Beat gaps simply stall the counter. fill_done pulses the cycle after the
// last beat, in the same cycle busy drops. Reset aborts a fill silently.
module cache_line_fill_ctrl import cache_pkg::*; #(
   parameter int unsigned WAYS  = WAYS_DEF,
   parameter int unsigned WORDS = WORDS_DEF,
   parameter int unsigned SW    = SET_W,
   parameter int unsigned WW    = WAY_W,
   parameter int unsigned OW    = OFF_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fill_start,
   input  logic [SW-1:0]         fill_set,
   input  logic [WW-1:0]         fill_way,
   input  logic                  fill_valid,
   output logic                  fill_ready,
   output logic                  fill_done,
   output logic                  busy,
   output logic                  idle,
   output logic                  wr_en,
   output logic [SW+WW+OW-1:0]   wr_addr
);
   localparam int unsigned   AW   = SW + WW + OW;
   localparam logic [OW-1:0] LAST = OW'(WORDS - 1);

   fill_state_e   state_q, state_d;
   logic [OW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] set_q, set_d;
   logic [WW-1:0] way_q, way_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          ready_q, ready_d;
   logic          beat;

   assign beat = ready_q && fill_valid;

   // Next-state logic for the fill FSM and its registered outputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      set_d   = set_q;
      way_d   = way_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      ready_d = ready_q;
      case (state_q)
         IDLE: begin
            if (fill_start) begin
               state_d = FILL;
               set_d   = fill_set;
               way_d   = fill_way;
               cnt_d   = '0;
               busy_d  = 1'b1;
               ready_d = 1'b1;
            end
         end
         FILL: begin
            if (beat) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  busy_d  = 1'b0;
                  ready_d = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Fill FSM registers; reset drops any fill in flight without a done pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         set_q   <= '0;
         way_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         set_q   <= set_d;
         way_q   <= way_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   assign fill_ready = ready_q;
   assign fill_done  = done_q;
   assign busy       = busy_q;
   assign idle       = (state_q == IDLE);
   // A beat presented in the reset cycle is dropped with the rest of the fill
   assign wr_en      = beat && !reset;
   assign wr_addr    = AW'(flat_index(32'(set_q), 32'(way_q), 32'(cnt_q), WAYS, WORDS));

endmodule

// File: rtl/cache_line_data_array.sv
// Set-associative cache data store: SETS x WAYS lines of WORDS words.
// CPU side: byte-enabled writes and single-word reads with one cycle of
// latency (registered read address); rd_data holds between reads.
// Refill side: cache_line_fill_ctrl streams a whole line into the array.
// Optional feature macro: CACHE_PARITY_EN adds one even-parity bit per byte
// and reports mismatches on rd_perr; without it rd_perr is tied low.
module cache_line_data_array import cache_pkg::*; #(
   parameter int unsigned DWIDTH = DWIDTH_DEF,
   parameter int unsigned SETS   = SETS_DEF,
   parameter int unsigned WAYS   = WAYS_DEF,
   parameter int unsigned WORDS  = WORDS_DEF
) (
   input logic                    clock,
   input logic                    reset,
   cache_line_data_array_if.slave bus
);
   localparam int unsigned SW    = $clog2(SETS);
   localparam int unsigned WW    = $clog2(WAYS);
   localparam int unsigned OW    = $clog2(WORDS);
   localparam int unsigned BW    = DWIDTH / 8;
   localparam int unsigned AW    = SW + WW + OW;
   localparam int unsigned DEPTH = SETS * WAYS * WORDS;

   logic              fill_idle;
   logic              fill_wen;
   logic [AW-1:0]     fill_addr;
   logic              cpu_ready;
   logic              cpu_acc;
   logic              cpu_wen;
   logic [AW-1:0]     cpu_addr;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [BW-1:0]     wr_be;
   logic [DWIDTH-1:0] wr_data;
   logic              rd_valid_q, rd_valid_d;
   logic [AW-1:0]     raddr_q, raddr_d;
   logic [DWIDTH-1:0] hold_q, hold_d;
   logic [DWIDTH-1:0] rd_word;
   logic              rd_perr_w;

   logic [BW-1:0][7:0] mem_q [DEPTH];

   cache_line_fill_ctrl #(
      .WAYS  (WAYS),
      .WORDS (WORDS),
      .SW    (SW),
      .WW    (WW),
      .OW    (OW)
   ) u_fill_ctrl (
      .clock      (clock),
      .reset      (reset),
      .fill_start (bus.fill_start),
      .fill_set   (bus.fill_set),
      .fill_way   (bus.fill_way),
      .fill_valid (bus.fill_valid),
      .fill_ready (bus.fill_ready),
      .fill_done  (bus.fill_done),
      .busy       (bus.busy),
      .idle       (fill_idle),
      .wr_en      (fill_wen),
      .wr_addr    (fill_addr)
   );

   // A fill request in the same cycle wins over the CPU
   assign cpu_ready = fill_idle && !bus.fill_start;
   assign cpu_acc   = bus.cpu_req && cpu_ready && !reset;
   assign cpu_wen   = cpu_acc && bus.cpu_we;
   assign cpu_addr  = AW'(flat_index(32'(bus.cpu_set), 32'(bus.cpu_way),
                                     32'(bus.cpu_word), WAYS, WORDS));

   // Write port mux: fill beats (whole word) or CPU writes (enabled bytes)
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = cpu_addr;
      wr_be   = bus.cpu_be;
      wr_data = bus.cpu_wdata;
      if (fill_wen) begin
         wr_en   = 1'b1;
         wr_addr = fill_addr;
         wr_be   = '1;
         wr_data = bus.fill_data;
      end else if (cpu_wen) begin
         wr_en   = 1'b1;
      end
   end

   // Byte-lane writes into the data array; contents survive reset
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int b = 0; b < int'(BW); b++) begin
            if (wr_be[b]) mem_q[wr_addr][b] <= wr_data[b*8 +: 8];
         end
      end
   end

   // Read address capture and output hold value
   always_comb begin
      rd_valid_d = cpu_acc && !bus.cpu_we;
      raddr_d    = rd_valid_d ? cpu_addr : raddr_q;
      hold_d     = rd_valid_q ? rd_word : hold_q;
   end

   // Read-side registers
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         raddr_q    <= '0;
         hold_q     <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         raddr_q    <= raddr_d;
         hold_q     <= hold_d;
      end
   end

   // Reading through the registered address makes a write in the previous
   // cycle visible without any bypass path
   assign rd_word = mem_q[raddr_q];

`ifdef CACHE_PARITY_EN
   logic [BW-1:0] par_q [DEPTH];
   logic [BW-1:0] wr_par;
   logic [BW-1:0] rd_par;

   generate
      for (genvar gi = 0; gi < int'(BW); gi++) begin : g_par
         assign wr_par[gi] = ^wr_data[gi*8 +: 8];
         assign rd_par[gi] = ^rd_word[gi*8 +: 8];
      end
   endgenerate

   // Parity bits follow the same byte enables as the data
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int b = 0; b < int'(BW); b++) begin
            if (wr_be[b]) par_q[wr_addr][b] <= wr_par[b];
         end
      end
   end

   assign rd_perr_w = rd_valid_q && (par_q[raddr_q] != rd_par);
`else
   assign rd_perr_w = 1'b0;
`endif

   assign bus.cpu_ready = cpu_ready;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_valid_q ? rd_word : hold_q;
   assign bus.rd_perr   = rd_perr_w;

endmodule

// File: tb/tb_cache_line_data_array.sv
// Self-checking bench for cache_line_data_array (default geometry 8x2x4x32).
// Reference model: a flat array of words indexed by (set, way, word).
module tb_cache_line_data_array;
   import cache_pkg::*;

   localparam int NWORDS = 4;
   localparam int NLINES = 64;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   cache_line_data_array_if bus_if ();

   cache_line_data_array dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   logic [31:0] ref_mem [NLINES];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic int idx(input int s, input int w, input int o);
      return (s * 2 + w) * NWORDS + o;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus_if.cpu_req    = 1'b0;
      bus_if.cpu_we     = 1'b0;
      bus_if.cpu_be     = 4'h0;
      bus_if.cpu_set    = 3'd0;
      bus_if.cpu_way    = 1'b0;
      bus_if.cpu_word   = 2'd0;
      bus_if.cpu_wdata  = 32'h0;
      bus_if.fill_start = 1'b0;
      bus_if.fill_set   = 3'd0;
      bus_if.fill_way   = 1'b0;
      bus_if.fill_valid = 1'b0;
      bus_if.fill_data  = 32'h0;
   endtask

   task automatic drive_cpu(input bit we, input int s, input int w, input int o,
                            input logic [3:0] be, input logic [31:0] d);
      bus_if.cpu_req   = 1'b1;
      bus_if.cpu_we    = we;
      bus_if.cpu_set   = 3'(s);
      bus_if.cpu_way   = 1'(w);
      bus_if.cpu_word  = 2'(o);
      bus_if.cpu_be    = be;
      bus_if.cpu_wdata = d;
   endtask

   // One CPU write transaction; the model merges enabled bytes
   task automatic do_write(input int s, input int w, input int o,
                           input logic [3:0] be, input logic [31:0] d);
      drive_cpu(1'b1, s, w, o, be, d);
      #1;
      n_checks++;
      if (bus_if.cpu_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_ready: cpu_ready=%b required 1", bus_if.cpu_ready);
      end
      tick();
      bus_if.cpu_req = 1'b0;
      bus_if.cpu_we  = 1'b0;
      for (int b = 0; b < 4; b++)
         if (be[b]) ref_mem[idx(s, w, o)][b*8 +: 8] = d[b*8 +: 8];
      n_checks++;
      if (bus_if.rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_no_rdvalid: rd_valid=%b required 0", bus_if.rd_valid);
      end
      $display("WR  set=%0d way=%0d word=%0d be=%h data=%h", s, w, o, be, d);
   endtask

   // One CPU read transaction checked against the model
   task automatic do_read(input int s, input int w, input int o,
                          input logic exp_perr, input string tag);
      drive_cpu(1'b0, s, w, o, 4'h0, 32'h0);
      #1;
      n_checks++;
      if (bus_if.cpu_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready: cpu_ready=%b required 1", tag, bus_if.cpu_ready);
      end
      tick();
      bus_if.cpu_req = 1'b0;
      n_checks++;
      if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== ref_mem[idx(s, w, o)]) begin
         n_fail++;
         $display("FAIL %s: rd_valid=%b rd_data=%h required 1/%h (set=%0d way=%0d word=%0d)",
                  tag, bus_if.rd_valid, bus_if.rd_data, ref_mem[idx(s, w, o)], s, w, o);
      end
      n_checks++;
      if (bus_if.rd_perr !== exp_perr) begin
         n_fail++;
         $display("FAIL %s perr: rd_perr=%b required %b", tag, bus_if.rd_perr, exp_perr);
      end
      $display("RD  set=%0d way=%0d word=%0d data=%h", s, w, o, bus_if.rd_data);
   endtask

   // One line fill; gap[k] idle cycles precede beat k; optionally a second
   // fill_start is issued during the first gap cycle and must be ignored
   task automatic do_fill(input int s, input int w, input logic [31:0] d [NWORDS],
                          input int gap [NWORDS], input bit inject);
      bit injected = 1'b0;
      bus_if.fill_start = 1'b1;
      bus_if.fill_set   = 3'(s);
      bus_if.fill_way   = 1'(w);
      #1;
      n_checks++;
      if (bus_if.cpu_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_start_ready: cpu_ready=%b required 0", bus_if.cpu_ready);
      end
      tick();
      bus_if.fill_start = 1'b0;
      n_checks++;
      if (bus_if.busy !== 1'b1 || bus_if.fill_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_enter: busy=%b fill_ready=%b required 1/1",
                  bus_if.busy, bus_if.fill_ready);
      end
      for (int k = 0; k < NWORDS; k++) begin
         for (int g = 0; g < gap[k]; g++) begin
            bus_if.fill_valid = 1'b0;
            if (inject && !injected) begin
               bus_if.fill_start = 1'b1;
               bus_if.fill_set   = 3'(s ^ 1);
               bus_if.fill_way   = 1'(w);
               injected = 1'b1;
            end
            tick();
            bus_if.fill_start = 1'b0;
            n_checks++;
            if (bus_if.fill_done !== 1'b0 || bus_if.busy !== 1'b1) begin
               n_fail++;
               $display("FAIL fill_gap: fill_done=%b busy=%b required 0/1",
                        bus_if.fill_done, bus_if.busy);
            end
         end
         bus_if.fill_valid = 1'b1;
         bus_if.fill_data  = d[k];
         tick();
         bus_if.fill_valid = 1'b0;
         ref_mem[idx(s, w, k)] = d[k];
         n_checks++;
         if (k < NWORDS - 1) begin
            if (bus_if.fill_done !== 1'b0 || bus_if.busy !== 1'b1) begin
               n_fail++;
               $display("FAIL fill_beat%0d: fill_done=%b busy=%b required 0/1",
                        k, bus_if.fill_done, bus_if.busy);
            end
         end else begin
            if (bus_if.fill_done !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.fill_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL fill_done: fill_done=%b busy=%b fill_ready=%b required 1/0/0",
                        bus_if.fill_done, bus_if.busy, bus_if.fill_ready);
            end
         end
      end
      tick();
      n_checks++;
      if (bus_if.fill_done !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_done_pulse: fill_done=%b required 0", bus_if.fill_done);
      end
      $display("FILL set=%0d way=%0d data=%h %h %h %h", s, w, d[0], d[1], d[2], d[3]);
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      drive_cpu(1'b0, 0, 0, 0, 4'h0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (bus_if.rd_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.fill_ready !== 1'b0 ||
             bus_if.fill_done !== 1'b0 || bus_if.rd_data !== 32'h0 || bus_if.rd_perr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rd_valid=%b busy=%b fill_ready=%b fill_done=%b rd_data=%h rd_perr=%b required all 0",
                     bus_if.rd_valid, bus_if.busy, bus_if.fill_ready, bus_if.fill_done,
                     bus_if.rd_data, bus_if.rd_perr);
         end
      end
      reset = 1'b0;
      tick();
      bus_if.cpu_req = 1'b0;
      n_checks++;
      if (bus_if.rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_read: rd_valid=%b required 1", bus_if.rd_valid);
      end
      tick();
      n_checks++;
      if (bus_if.rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_rdvalid: rd_valid=%b required 0", bus_if.rd_valid);
      end
      $display("RST done");
   endtask

   task automatic test_init();
      for (int s = 0; s < 8; s++)
         for (int w = 0; w < 2; w++)
            for (int o = 0; o < NWORDS; o++)
               do_write(s, w, o, 4'hF, $urandom);
   endtask

   task automatic test_partial_write();
      do_write(3, 1, 2, 4'hF, 32'hDEADBEEF);
      do_write(3, 1, 2, 4'b0010, 32'h00001100);
      do_read(3, 1, 2, 1'b0, "partial_model");
      n_checks++;
      if (bus_if.rd_data !== 32'hDEAD11EF) begin
         n_fail++;
         $display("FAIL partial_const: rd_data=%h required deadbeef merged -> dead11ef", bus_if.rd_data);
      end
   endtask

   task automatic test_fill_gap();
      logic [31:0] d [NWORDS];
      int gap [NWORDS];
      // fill_valid while idle must be ignored
      bus_if.fill_valid = 1'b1;
      bus_if.fill_data  = 32'hBAD0BAD0;
      #1;
      n_checks++;
      if (bus_if.fill_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_fill_ready: fill_ready=%b required 0", bus_if.fill_ready);
      end
      tick();
      bus_if.fill_valid = 1'b0;
      do_read(0, 0, 0, 1'b0, "idle_beat_ignored");
      for (int k = 0; k < NWORDS; k++) begin
         d[k]   = 32'hA0 + 32'(k);
         gap[k] = (k == 2) ? 2 : 0;
      end
      do_fill(5, 0, d, gap, 1'b1);
      for (int k = 0; k < NWORDS; k++) do_read(5, 0, k, 1'b0, "fill_word");
      for (int k = 0; k < NWORDS; k++) do_read(4, 0, k, 1'b0, "fill_restart_ignored");
   endtask

   task automatic test_start_collision();
      logic [31:0] d [NWORDS];
      for (int k = 0; k < NWORDS; k++) d[k] = $urandom;
      drive_cpu(1'b0, 1, 1, 0, 4'h0, 32'h0);
      bus_if.fill_start = 1'b1;
      bus_if.fill_set   = 3'd1;
      bus_if.fill_way   = 1'b1;
      #1;
      n_checks++;
      if (bus_if.cpu_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_ready: cpu_ready=%b required 0", bus_if.cpu_ready);
      end
      tick();
      bus_if.fill_start = 1'b0;
      n_checks++;
      if (bus_if.rd_valid !== 1'b0 || bus_if.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL collide_fill_wins: rd_valid=%b busy=%b required 0/1",
                  bus_if.rd_valid, bus_if.busy);
      end
      for (int k = 0; k < NWORDS; k++) begin
         bus_if.fill_valid = 1'b1;
         bus_if.fill_data  = d[k];
         #1;
         n_checks++;
         if (bus_if.cpu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_ready_fill%0d: cpu_ready=%b required 0", k, bus_if.cpu_ready);
         end
         tick();
         ref_mem[idx(1, 1, k)] = d[k];
      end
      bus_if.fill_valid = 1'b0;
      #1;
      n_checks++;
      if (bus_if.fill_done !== 1'b1 || bus_if.cpu_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL collide_done_ready: fill_done=%b cpu_ready=%b required 1/1",
                  bus_if.fill_done, bus_if.cpu_ready);
      end
      tick();
      bus_if.cpu_req = 1'b0;
      n_checks++;
      if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== d[0]) begin
         n_fail++;
         $display("FAIL collide_late_read: rd_valid=%b rd_data=%h required 1/%h",
                  bus_if.rd_valid, bus_if.rd_data, d[0]);
      end
      $display("COLLIDE fill set=1 way=1 then read data=%h", bus_if.rd_data);
   endtask

   task automatic test_reset_abort();
      logic [31:0] d [NWORDS];
      for (int k = 0; k < NWORDS; k++) d[k] = $urandom;
      bus_if.fill_start = 1'b1;
      bus_if.fill_set   = 3'd2;
      bus_if.fill_way   = 1'b1;
      tick();
      bus_if.fill_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus_if.fill_valid = 1'b1;
         bus_if.fill_data  = d[k];
         tick();
         ref_mem[idx(2, 1, k)] = d[k];
      end
      reset = 1'b1;
      bus_if.fill_data = d[2];
      tick();
      reset = 1'b0;
      bus_if.fill_valid = 1'b0;
      n_checks++;
      if (bus_if.busy !== 1'b0 || bus_if.fill_done !== 1'b0 || bus_if.fill_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_state: busy=%b fill_done=%b fill_ready=%b required 0/0/0",
                  bus_if.busy, bus_if.fill_done, bus_if.fill_ready);
      end
      tick();
      n_checks++;
      if (bus_if.fill_done !== 1'b0 || bus_if.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: fill_done=%b busy=%b required 0/0",
                  bus_if.fill_done, bus_if.busy);
      end
      for (int k = 0; k < NWORDS; k++) do_read(2, 1, k, 1'b0, "abort_word");
   endtask

   task automatic test_back_to_back();
      logic [31:0] nd;
      logic [31:0] held;
      nd = $urandom;
      drive_cpu(1'b1, 4, 1, 3, 4'hF, nd);
      tick();
      ref_mem[idx(4, 1, 3)] = nd;
      drive_cpu(1'b0, 4, 1, 3, 4'h0, 32'h0);
      tick();
      bus_if.cpu_req = 1'b0;
      n_checks++;
      if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== nd) begin
         n_fail++;
         $display("FAIL raw: rd_valid=%b rd_data=%h required 1/%h", bus_if.rd_valid, bus_if.rd_data, nd);
      end
      for (int k = 0; k < NWORDS; k++) begin
         drive_cpu(1'b0, 6, 1, k, 4'h0, 32'h0);
         tick();
         n_checks++;
         if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== ref_mem[idx(6, 1, k)]) begin
            n_fail++;
            $display("FAIL stream%0d: rd_valid=%b rd_data=%h required 1/%h",
                     k, bus_if.rd_valid, bus_if.rd_data, ref_mem[idx(6, 1, k)]);
         end
      end
      bus_if.cpu_req = 1'b0;
      held = ref_mem[idx(6, 1, 3)];
      tick();
      n_checks++;
      if (bus_if.rd_valid !== 1'b0 || bus_if.rd_data !== held) begin
         n_fail++;
         $display("FAIL hold: rd_valid=%b rd_data=%h required 0/%h", bus_if.rd_valid, bus_if.rd_data, held);
      end
      do_write(6, 1, 3, 4'hF, ~held);
      n_checks++;
      if (bus_if.rd_data !== held) begin
         n_fail++;
         $display("FAIL hold_after_write: rd_data=%h required %h", bus_if.rd_data, held);
      end
      $display("B2B done");
   endtask

   task automatic test_random();
      logic [31:0] d [NWORDS];
      int gap [NWORDS];
      for (int it = 0; it < 150; it++) begin
         int op, s, w, o;
         op = $urandom_range(0, 9);
         s  = $urandom_range(0, 7);
         w  = $urandom_range(0, 1);
         o  = $urandom_range(0, 3);
         if (op < 4) begin
            do_write(s, w, o, 4'($urandom_range(0, 15)), $urandom);
         end else if (op < 8) begin
            do_read(s, w, o, 1'b0, "rand_read");
         end else if (op == 8) begin
            for (int k = 0; k < NWORDS; k++) begin
               d[k]   = $urandom;
               gap[k] = $urandom_range(0, 2);
            end
            do_fill(s, w, d, gap, 1'($urandom_range(0, 1)));
         end else begin
            tick();
         end
      end
   endtask

   task automatic test_parity();
`ifdef CACHE_PARITY_EN
      int i;
      i = idx(7, 0, 1);
      dut.mem_q[i][0][3] = ~dut.mem_q[i][0][3];
      ref_mem[i][3] = ~ref_mem[i][3];
      do_read(7, 0, 1, 1'b1, "parity_flip");
      do_read(7, 0, 2, 1'b0, "parity_clean");
      do_write(7, 0, 1, 4'hF, 32'h13579BDF);
      do_read(7, 0, 1, 1'b0, "parity_rewritten");
`else
      do_read(7, 0, 1, 1'b0, "parity_off");
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      test_reset();
      test_init();
      test_partial_write();
      test_fill_gap();
      test_start_collision();
      test_reset_abort();
      test_back_to_back();
      test_random();
      test_parity();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
